// File: rtl/divider_sequencer.sv
// Programmable divide-by-N tick sequencer (start/stop, bursts, safe divisor reload); start->first y in 1 cycle,
// stop->IDLE within div_cur cycles; no backpressure, y is a free-running 1-cycle enable to consumers.
module divider_sequencer #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               div_wr,
  input  logic [CNT_W-1:0]   div_in,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   div_cur,
  output logic               div_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   DIV_RST   = CNT_W'(3);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0]   div_cur_q, div_cur_d;
  logic               pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic               done_q, done_d;
  logic               div_err_q, div_err_d;

  logic               y_int;
  logic               wrap;
  logic               div_ok;
  logic [BURST_W-1:0] tick_nxt;
  logic               burst_end;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tick_cnt_d = tick_cnt_q;
    burst_d    = burst_q;
    div_cur_d  = div_cur_q;
    pend_vld_d = pend_vld_q;
    pend_div_d = pend_div_q;
    done_d     = 1'b0;
    div_err_d  = div_wr && (div_in == '0);

    y_int  = (state_q == S_RUN) && (cnt_q == '0);
    wrap   = (state_q != S_IDLE) && (cnt_q == div_cur_q - CNT_ONE);
    div_ok = div_wr && (div_in != '0);
    // Count this cycle's tick before the burst test so N=1 (tick on every wrap) emits exactly burst_len ticks.
    tick_nxt  = (y_int && (tick_cnt_q != '1)) ? tick_cnt_q + BURST_ONE : tick_cnt_q;
    burst_end = (burst_q != '0) && (tick_nxt == burst_q);

    case (state_q)
      S_IDLE: begin
        pend_vld_d = 1'b0;
        if (div_ok) div_cur_d = div_in;
        if (start && !stop) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          tick_cnt_d = '0;
          burst_d    = burst_len;
        end
      end
      S_RUN, S_DRAIN: begin
        tick_cnt_d = tick_nxt;
        if (div_ok) begin
          pend_vld_d = 1'b1;
          pend_div_d = div_in;
        end
        if (wrap) begin
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          // A write landing on the wrap edge wins over any older pending value.
          if (div_ok)          div_cur_d = div_in;
          else if (pend_vld_q) div_cur_d = pend_div_q;
          if (burst_end || stop || (state_q == S_DRAIN)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if ((state_q == S_RUN) && stop) state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tick_cnt_q <= '0;
      burst_q    <= '0;
      div_cur_q  <= DIV_RST;
      pend_vld_q <= 1'b0;
      pend_div_q <= '0;
      done_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_cnt_q <= tick_cnt_d;
      burst_q    <= burst_d;
      div_cur_q  <= div_cur_d;
      pend_vld_q <= pend_vld_d;
      pend_div_q <= pend_div_d;
      done_q     <= done_d;
      div_err_q  <= div_err_d;
    end
  end

  assign y       = y_int;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign div_cur = div_cur_q;
  assign div_err = div_err_q;

endmodule
